// File: rtl/wb_port_arbiter_if.sv
// wb_port_arbiter_if: writeback, multicycle-result, lookup and register-file port bundle.
interface wb_port_arbiter_if;
    logic        pipe_we;
    logic [4:0]  pipe_addr;
    logic [31:0] pipe_data;
    logic        mc_valid;
    logic [4:0]  mc_addr;
    logic [31:0] mc_data;
    logic        mc_ready;
    logic [4:0]  q_addr;
    logic        q_pending;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        stall_wb;
    modport master (
        output pipe_we, pipe_addr, pipe_data, mc_valid, mc_addr, mc_data, q_addr,
        input  mc_ready, q_pending, rf_we, rf_waddr, rf_wdata, stall_wb
    );
    modport slave (
        input  pipe_we, pipe_addr, pipe_data, mc_valid, mc_addr, mc_data, q_addr,
        output mc_ready, q_pending, rf_we, rf_waddr, rf_wdata, stall_wb
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between writeback and a buffered multicycle unit.
module wb_port_arbiter #(
    parameter int MC_DEPTH = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    wb_port_arbiter_if.slave bus
);
    localparam int AW = $clog2(MC_DEPTH);
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] PEND  = 2'd1;
    localparam logic [1:0] FORCE = 2'd2;
    logic [4:0]    r_addr [MC_DEPTH];
    logic [31:0]   r_data [MC_DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [AW:0]   r_cnt, w_cnt_nx;
    logic [1:0]    r_state, w_state_nx;
    logic [WW-1:0] r_wait, w_wait_nx;
    logic [4:0]    w_head;
    logic          w_ne, w_full, w_force, w_pipe_req, w_grant, w_deny, w_pop, w_push, w_hit;
    assign w_head     = r_addr[r_rp];
    assign w_ne       = r_cnt != '0;
    assign w_full     = r_cnt == (AW+1)'(MC_DEPTH);
    assign w_force    = r_state == FORCE;
    assign w_pipe_req = bus.pipe_we && bus.pipe_addr != 5'd0;
    assign w_grant    = w_ne && w_head != 5'd0 && (!w_pipe_req || w_force);
    assign w_deny     = w_ne && w_head != 5'd0 && !w_grant;
    // Zero-destination entries are discarded without touching the port.
    assign w_pop      = w_ne && (w_head == 5'd0 || w_grant);
    assign w_push     = bus.mc_valid && !w_full;
    assign w_cnt_nx   = r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    assign bus.mc_ready  = !w_full;
    assign bus.stall_wb  = w_force;
    assign bus.rf_we     = rst_n && (w_grant || (w_pipe_req && !w_force));
    assign bus.rf_waddr  = w_grant ? w_head : bus.pipe_addr;
    assign bus.rf_wdata  = w_grant ? r_data[r_rp] : bus.pipe_data;
    assign bus.q_pending = w_hit && bus.q_addr != 5'd0;
    always_comb begin
        w_hit = 1'b0;
        for (int k = 0; k < MC_DEPTH; k++)
            if ((AW+1)'(k) < r_cnt && r_addr[r_rp + AW'(k)] == bus.q_addr) w_hit = 1'b1;
    end
    always_comb begin
        w_state_nx = w_cnt_nx == '0 ? IDLE :
                     (w_deny && r_wait == WW'(MAX_WAIT - 1)) ? FORCE : PEND;
        w_wait_nx  = (w_cnt_nx == '0 || w_grant || w_state_nx == FORCE) ? '0 :
                     w_deny ? r_wait + WW'(1) : r_wait;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_cnt   <= '0;
            r_state <= IDLE;
            r_wait  <= '0;
        end else begin
            r_wp    <= r_wp + AW'(w_push);
            r_rp    <= r_rp + AW'(w_pop);
            r_cnt   <= w_cnt_nx;
            r_state <= w_state_nx;
            r_wait  <= w_wait_nx;
        end
    end
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_wp] <= bus.mc_addr;
            r_data[r_wp] <= bus.mc_data;
        end
    end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed scenarios plus a randomized run against a queue-based model.
module tb_wb_port_arbiter;
    localparam int D  = 2;
    localparam int MW = 4;
    typedef struct { logic [4:0] a; logic [31:0] d; } ent_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_chk = 0;
    int n_fail = 0;
    always #5 clk = ~clk;
    wb_port_arbiter_if bus();
    wb_port_arbiter #(.MC_DEPTH(D), .MAX_WAIT(MW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    task automatic idle_inputs();
        bus.pipe_we = 0; bus.pipe_addr = 0; bus.pipe_data = 0;
        bus.mc_valid = 0; bus.mc_addr = 0; bus.mc_data = 0; bus.q_addr = 0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        tick();
        rst_n = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        tick();
        rst_n = 1;
        tick();
        bus.pipe_we = 1; bus.pipe_addr = 5; bus.pipe_data = 32'h11;
        @(negedge clk);
        rst_n = 0;
        #1;
        n_chk++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_rf_we got %b want 0", bus.rf_we); end
        n_chk++; if (bus.mc_ready !== 1'b1) begin n_fail++; $display("FAIL reset_mc_ready got %b want 1", bus.mc_ready); end
        n_chk++; if (bus.stall_wb !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", bus.stall_wb); end
        n_chk++; if (bus.q_pending !== 1'b0) begin n_fail++; $display("FAIL reset_q_pending got %b want 0", bus.q_pending); end
        tick();
        rst_n = 1;
        @(negedge clk);
        n_chk++;
        if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 5'd5, 32'h11}) begin
            n_fail++; $display("FAIL idle_pipe_write got we=%b a=%0d d=%h want we=1 a=5 d=11", bus.rf_we, bus.rf_waddr, bus.rf_wdata);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_drain();
        do_reset();
        bus.mc_valid = 1; bus.mc_addr = 8; bus.mc_data = 32'hAB; bus.q_addr = 8;
        @(negedge clk);
        n_chk++; if (bus.rf_we !== 1'b0 || bus.mc_ready !== 1'b1) begin n_fail++; $display("FAIL drain_push got we=%b rdy=%b want we=0 rdy=1", bus.rf_we, bus.mc_ready); end
        tick();
        bus.mc_valid = 0;
        @(negedge clk);
        n_chk++;
        if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.stall_wb, bus.q_pending} !== {1'b1, 5'd8, 32'hAB, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL drain_write got we=%b a=%0d d=%h st=%b qp=%b want 1 8 ab 0 1", bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.stall_wb, bus.q_pending);
        end
        tick();
        @(negedge clk);
        n_chk++;
        if ({bus.rf_we, bus.q_pending, bus.mc_ready, bus.stall_wb} !== 4'b0010) begin
            n_fail++; $display("FAIL drain_empty got we=%b qp=%b rdy=%b st=%b want 0 0 1 0", bus.rf_we, bus.q_pending, bus.mc_ready, bus.stall_wb);
        end
        tick();
    endtask

    task automatic test_starve();
        do_reset();
        bus.pipe_we = 1; bus.pipe_addr = 5;
        for (int i = 0; i < 5; i++) begin
            bus.pipe_data = 32'h100 + i;
            bus.mc_valid = (i == 0); bus.mc_addr = 9; bus.mc_data = 32'h99;
            @(negedge clk);
            n_chk++;
            if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.stall_wb} !== {1'b1, 5'd5, 32'h100 + i, 1'b0}) begin
                n_fail++; $display("FAIL starve_pipe%0d got we=%b a=%0d d=%h st=%b", i, bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.stall_wb);
            end
            tick();
        end
        bus.mc_valid = 0;
        bus.pipe_data = 32'h200;
        @(negedge clk);
        n_chk++;
        if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.stall_wb} !== {1'b1, 5'd9, 32'h99, 1'b1}) begin
            n_fail++; $display("FAIL starve_force got we=%b a=%0d d=%h st=%b want 1 9 99 1", bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.stall_wb);
        end
        tick();
        @(negedge clk);
        n_chk++;
        if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.stall_wb} !== {1'b1, 5'd5, 32'h200, 1'b0}) begin
            n_fail++; $display("FAIL starve_resume got we=%b a=%0d d=%h st=%b want 1 5 200 0", bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.stall_wb);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_full();
        int k = 0;
        bit acc;
        do_reset();
        bus.pipe_addr = 6;
        for (int c = 0; c < 10; c++) begin
            bus.pipe_we = (c < 7); bus.pipe_data = c;
            bus.mc_valid = (k < 3); bus.mc_addr = 5'(10 + k); bus.mc_data = 32'hA0 + k;
            @(negedge clk);
            if (c == 2) begin
                n_chk++; if (bus.mc_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got %b want 0", bus.mc_ready); end
            end
            if (c == 5) begin
                n_chk++;
                if ({bus.stall_wb, bus.rf_waddr, bus.rf_wdata, bus.mc_ready} !== {1'b1, 5'd10, 32'hA0, 1'b0}) begin
                    n_fail++; $display("FAIL full_force got st=%b a=%0d d=%h rdy=%b want 1 10 a0 0", bus.stall_wb, bus.rf_waddr, bus.rf_wdata, bus.mc_ready);
                end
            end
            if (c == 6) begin
                n_chk++;
                if ({bus.mc_ready, bus.stall_wb, bus.rf_we, bus.rf_waddr} !== {1'b1, 1'b0, 1'b1, 5'd6}) begin
                    n_fail++; $display("FAIL full_after got rdy=%b st=%b we=%b a=%0d want 1 0 1 6", bus.mc_ready, bus.stall_wb, bus.rf_we, bus.rf_waddr);
                end
            end
            if (c == 7 || c == 8) begin
                n_chk++;
                if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 5'(4 + c), 32'hA0 + c - 6}) begin
                    n_fail++; $display("FAIL full_order%0d got we=%b a=%0d d=%h", c, bus.rf_we, bus.rf_waddr, bus.rf_wdata);
                end
            end
            if (c == 9) begin
                n_chk++; if (bus.rf_we !== 1'b0 || bus.mc_ready !== 1'b1) begin n_fail++; $display("FAIL full_empty got we=%b rdy=%b want 0 1", bus.rf_we, bus.mc_ready); end
            end
            acc = bus.mc_valid && bus.mc_ready;
            tick();
            if (acc) k++;
        end
        idle_inputs();
    endtask

    task automatic test_zero();
        do_reset();
        bus.pipe_we = 1; bus.pipe_addr = 7; bus.q_addr = 3;
        for (int c = 0; c < 9; c++) begin
            bus.pipe_data = c;
            bus.mc_valid = (c < 2); bus.mc_addr = (c == 0) ? 5'd0 : 5'd3; bus.mc_data = (c == 0) ? 32'h5 : 32'h33;
            @(negedge clk);
            n_chk++;
            if (bus.q_pending !== (c >= 2 && c <= 6)) begin n_fail++; $display("FAIL zero_qpend%0d got %b", c, bus.q_pending); end
            n_chk++;
            if (bus.rf_we !== 1'b1 || bus.rf_waddr == 5'd0) begin n_fail++; $display("FAIL zero_port%0d got we=%b a=%0d", c, bus.rf_we, bus.rf_waddr); end
            if (c == 6) begin
                n_chk++;
                if ({bus.stall_wb, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 5'd3, 32'h33}) begin
                    n_fail++; $display("FAIL zero_force got st=%b a=%0d d=%h want 1 3 33", bus.stall_wb, bus.rf_waddr, bus.rf_wdata);
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_reset_force();
        bit seen = 0;
        do_reset();
        bus.pipe_we = 1; bus.pipe_addr = 4;
        for (int c = 0; c < 12 && !seen; c++) begin
            bus.mc_valid = (c == 0); bus.mc_addr = 9; bus.mc_data = 32'h77;
            @(negedge clk);
            if (bus.stall_wb === 1'b1) seen = 1;
            else tick();
        end
        n_chk++;
        if (!seen) begin n_fail++; $display("FAIL rstforce_timeout got no stall want stall within 12 cycles"); end
        rst_n = 0;
        #1;
        n_chk++;
        if (bus.stall_wb !== 1'b0 || bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL rstforce_now got st=%b we=%b want 0 0", bus.stall_wb, bus.rf_we); end
        tick();
        rst_n = 1; bus.pipe_we = 0; bus.mc_valid = 0; bus.q_addr = 9;
        @(negedge clk);
        n_chk++;
        if ({bus.q_pending, bus.mc_ready, bus.rf_we, bus.stall_wb} !== 4'b0100) begin
            n_fail++; $display("FAIL rstforce_after got qp=%b rdy=%b we=%b st=%b want 0 1 0 0", bus.q_pending, bus.mc_ready, bus.rf_we, bus.stall_wb);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_random();
        ent_t mq[$];
        int mwait = 0;
        bit mforce = 0, was_force = 0, hold = 0;
        bit preq, g, pop, push, deny, qp;
        logic [40:0] exp_v, got_v;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (!was_force) begin
                bus.pipe_we = $urandom_range(0, 9) < 7;
                bus.pipe_addr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                bus.pipe_data = $urandom;
            end
            if (!hold) begin
                bus.mc_valid = $urandom_range(0, 9) < 4;
                bus.mc_addr = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                bus.mc_data = $urandom;
            end
            bus.q_addr = (mq.size() > 0 && $urandom_range(0, 1)) ? mq[$urandom_range(0, mq.size() - 1)].a : 5'($urandom_range(0, 31));
            @(negedge clk);
            preq = bus.pipe_we && bus.pipe_addr != 0;
            g = mq.size() > 0 && mq[0].a != 0 && (!preq || mforce);
            qp = 0;
            foreach (mq[i]) if (mq[i].a == bus.q_addr && bus.q_addr != 0) qp = 1;
            exp_v = {g || (preq && !mforce), g ? mq[0].a : bus.pipe_addr, g ? mq[0].d : bus.pipe_data,
                     mforce, mq.size() < D, qp};
            got_v = {bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.stall_wb, bus.mc_ready, bus.q_pending};
            n_chk++;
            if (got_v !== exp_v) begin n_fail++; $display("FAIL random_c%0d got %h want %h", c, got_v, exp_v); end
            push = bus.mc_valid && mq.size() < D;
            pop = mq.size() > 0 && (mq[0].a == 0 || g);
            deny = mq.size() > 0 && mq[0].a != 0 && !g;
            hold = bus.mc_valid && !push;
            was_force = mforce;
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back('{bus.mc_addr, bus.mc_data});
            if (mforce) begin mforce = 0; mwait = 0; end
            else if (deny) begin
                if (mwait == MW - 1) begin mforce = 1; mwait = 0; end
                else mwait++;
            end else if (g) mwait = 0;
            if (mq.size() == 0) mwait = 0;
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 0;
                #1;
                n_chk++;
                if ({bus.rf_we, bus.stall_wb, bus.mc_ready} !== 3'b001) begin n_fail++; $display("FAIL random_rst%0d got we=%b st=%b rdy=%b", c, bus.rf_we, bus.stall_wb, bus.mc_ready); end
                mq.delete(); mwait = 0; mforce = 0; was_force = 0; hold = 0;
                tick();
                rst_n = 1;
            end else tick();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_drain();
        test_starve();
        test_full();
        test_zero();
        test_reset_force();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
